// File: rtl/chan_select_decoder_if.sv
// Select-load handshake between sonar control and chan_select_decoder.
// The master drives a channel index; the decoder raises in_ready when it can take it.
interface chan_select_decoder_if #(
  parameter int SEL_W = 5
);
  logic             in_valid;
  logic [SEL_W-1:0] in_sel;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_sel,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    output in_ready
  );
endinterface

// File: rtl/chan_select_decoder.sv
// Registered binary-to-one-hot channel decoder with direct load and dwell-timed scan.
// DECODER_PULSE_EN: direct-mode output lasts one cycle per accepted select.
module chan_select_decoder #(
  parameter int SEL_W   = 5,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  chan_select_decoder_if.slave    sel,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic [SEL_W-1:0]        scan_last,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    scan_wrap
);

  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               vld_q, vld_d;
  logic               wrap_q, wrap_d;
  logic               accept;

  assign sel.in_ready = (state_q == DIRECT) & en & ~mode;
  assign accept       = sel.in_valid & sel.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        vld_d = 1'b0;
        cnt_d = '0;
        if (en && mode) begin
          state_d = SCAN;
          sel_d   = '0;
          vld_d   = 1'b1;
        end else if (en) begin
          state_d = DIRECT;
        end
      end
      DIRECT: begin
        if (!en || mode) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end else if (accept) begin
          sel_d = sel.in_sel;
          vld_d = 1'b1;
        end
`ifdef DECODER_PULSE_EN
        else begin
          vld_d = 1'b0;
        end
`endif
      end
      SCAN: begin
        if (!en || !mode) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == dwell) begin
          cnt_d = '0;
          // >= so a live shrink of scan_last still wraps
          if (sel_q >= scan_last) begin
            sel_d  = '0;
            wrap_d = 1'b1;
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign out       = vld_q ? (ONE << sel_q) : '0;
  assign out_valid = vld_q;
  assign cur_sel   = sel_q;
  assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_chan_select_decoder.sv
// Self-checking bench for chan_select_decoder: direct loads, scans, en/mode exits, reset.
// Expected values come from elapsed-cycle arithmetic and an accepted-select record.
module tb_chan_select_decoder;
  localparam int SEL_W   = 5;
  localparam int DWELL_W = 8;
  localparam int N       = 1 << SEL_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               mode;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   scan_last;
  logic [N-1:0]       out;
  logic               out_valid;
  logic [SEL_W-1:0]   cur_sel;
  logic               scan_wrap;

  int vectors     = 0;
  int miscompares = 0;

  chan_select_decoder_if #(.SEL_W(SEL_W)) sel_if ();

  chan_select_decoder #(
    .SEL_W  (SEL_W),
    .DWELL_W(DWELL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .sel      (sel_if),
    .dwell    (dwell),
    .scan_last(scan_last),
    .out      (out),
    .out_valid(out_valid),
    .cur_sel  (cur_sel),
    .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] onehot_of(int idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    mode = 1'b0;
    sel_if.in_valid = 1'b0;
    sel_if.in_sel = '0;
    dwell = '0;
    scan_last = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (out !== '0 || out_valid !== 1'b0 || scan_wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: out=%h vld=%b wrap=%b, want 0/0/0", out, out_valid, scan_wrap);
    end
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (out !== '0 || out_valid !== 1'b0 || sel_if.in_ready !== 1'b0 || cur_sel !== '0) begin
      miscompares++;
      $display("FAIL reset_release: out=%h vld=%b rdy=%b sel=%0d, want 0/0/0/0",
               out, out_valid, sel_if.in_ready, cur_sel);
    end
  endtask

  task automatic test_direct();
    logic [N-1:0] fixed_out [3];
    int           fixed_sel [3];
    logic         exp_v;
    int           exp_sel;
    logic         v;
    int           s;
    logic [N-1:0] exp_out;
    fixed_out[0] = 32'h0000_0001;
    fixed_out[1] = 32'h0000_0080;
    fixed_out[2] = 32'h8000_0000;
    fixed_sel[0] = 0;
    fixed_sel[1] = 7;
    fixed_sel[2] = 31;
    en = 1'b1;
    mode = 1'b0;
    sel_if.in_valid = 1'b0;
    tick();
    exp_v = 1'b0;
    exp_sel = 0;
    for (int i = 0; i < 43; i++) begin
      v = (i < 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
      s = (i < 3) ? fixed_sel[i] : int'($urandom_range(0, N - 1));
      sel_if.in_valid = v;
      sel_if.in_sel = SEL_W'(s);
      vectors++;
      if (sel_if.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL direct_ready[%0d]: in_ready=%b want 1", i, sel_if.in_ready);
      end
      tick();
      if (v) begin
        exp_v = 1'b1;
        exp_sel = s;
      end else begin
`ifdef DECODER_PULSE_EN
        exp_v = 1'b0;
`endif
      end
      exp_out = exp_v ? onehot_of(exp_sel) : '0;
      if (i < 3) exp_out = fixed_out[i];
      vectors++;
      if (out !== exp_out || out_valid !== exp_v || (exp_v && cur_sel !== SEL_W'(exp_sel))) begin
        miscompares++;
        $display("FAIL direct_out[%0d]: out=%h vld=%b sel=%0d, want %h/%b/%0d",
                 i, out, out_valid, cur_sel, exp_out, exp_v, exp_sel);
      end
      vectors++;
      if (!(out == '0 || $onehot(out)) || out_valid !== (|out)) begin
        miscompares++;
        $display("FAIL direct_onehot[%0d]: out=%h vld=%b", i, out, out_valid);
      end
    end
    sel_if.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_accept();
    logic [N-1:0] exp_after;
`ifdef DECODER_PULSE_EN
    exp_after = '0;
`else
    exp_after = 32'h0000_0010;
`endif
    sel_if.in_valid = 1'b1;
    sel_if.in_sel = 5'd4;
    tick();
    sel_if.in_valid = 1'b0;
    vectors++;
    if (out !== 32'h0000_0010 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_accept: out=%h vld=%b, want 00000010/1", out, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out !== exp_after || out_valid !== (|exp_after)) begin
        miscompares++;
        $display("FAIL single_after[%0d]: out=%h vld=%b, want %h", i, out, out_valid, exp_after);
      end
    end
  endtask

  task automatic test_en_drop();
    sel_if.in_valid = 1'b1;
    sel_if.in_sel = 5'd9;
    en = 1'b0;
    #1;
    vectors++;
    if (sel_if.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop_ready: in_ready=%b want 0", sel_if.in_ready);
    end
    tick();
    vectors++;
    if (out !== '0 || out_valid !== 1'b0 || sel_if.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop_out: out=%h vld=%b rdy=%b, want 0/0/0", out, out_valid, sel_if.in_ready);
    end
    tick();
    vectors++;
    if (out !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en_drop_ignored: out=%h vld=%b, want 0/0", out, out_valid);
    end
    sel_if.in_valid = 1'b0;
  endtask

  task automatic test_scan(int d, int l);
    int           period;
    int           exp_ch;
    logic         exp_wrap;
    logic [N-1:0] exp_out;
    en = 1'b0;
    tick();
    dwell = DWELL_W'(d);
    scan_last = SEL_W'(l);
    en = 1'b1;
    mode = 1'b1;
    period = (l + 1) * (d + 1);
    for (int t = 0; t < 2 * period + 2; t++) begin
      tick();
      exp_ch = (t / (d + 1)) % (l + 1);
      exp_wrap = (t > 0) && (t % period == 0);
      exp_out = onehot_of(exp_ch);
      vectors++;
      if (out !== exp_out || out_valid !== 1'b1 || cur_sel !== SEL_W'(exp_ch) ||
          scan_wrap !== exp_wrap || sel_if.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL scan_d%0d_l%0d[t=%0d]: out=%h sel=%0d vld=%b wrap=%b rdy=%b, want %h/%0d/1/%b/0",
                 d, l, t, out, cur_sel, out_valid, scan_wrap, sel_if.in_ready,
                 exp_out, exp_ch, exp_wrap);
      end
    end
  endtask

  task automatic test_mode_flip();
    en = 1'b0;
    tick();
    dwell = 8'd1;
    scan_last = 5'd2;
    en = 1'b1;
    mode = 1'b1;
    repeat (4) tick();
    mode = 1'b0;
    tick();
    vectors++;
    if (out !== '0 || out_valid !== 1'b0 || sel_if.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flip_idle: out=%h vld=%b rdy=%b, want 0/0/0", out, out_valid, sel_if.in_ready);
    end
    tick();
    vectors++;
    if (out !== '0 || sel_if.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flip_direct: out=%h rdy=%b, want 0/1", out, sel_if.in_ready);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0;
    tick();
    dwell = 8'd3;
    scan_last = 5'd5;
    en = 1'b1;
    mode = 1'b1;
    repeat (6) tick();
    vectors++;
    if (out !== onehot_of(1) || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_pre: out=%h vld=%b, want %h/1", out, out_valid, onehot_of(1));
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out !== '0 || out_valid !== 1'b0 || cur_sel !== '0 || scan_wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_now: out=%h vld=%b sel=%0d wrap=%b, want 0", out, out_valid, cur_sel, scan_wrap);
    end
    en = 1'b0;
    mode = 1'b0;
    #3;
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (out !== '0 || sel_if.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_after: out=%h rdy=%b, want 0/0", out, sel_if.in_ready);
    end
    en = 1'b1;
    mode = 1'b1;
    tick();
    vectors++;
    if (out !== onehot_of(0) || cur_sel !== '0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL areset_resume: out=%h sel=%0d vld=%b, want 1/0/1", out, cur_sel, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_single_accept();
    test_en_drop();
    test_scan(2, 3);
    test_scan(0, 0);
    for (int k = 0; k < 3; k++) begin
      test_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
    end
    test_mode_flip();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
